// File: rtl/mmio_timer_irq_if.sv
// mmio_timer_irq_if
// -----------------
// Data-memory bus seen by the countdown timer. The CPU side (master) drives
// the store strobe, address and store data. The timer side (slave) returns
// read data and a window-hit flag, which top uses to select the read data.
//
// Signals:
//   MemWrite   master->slave  1   CPU store strobe
//   DataAdr    master->slave  32  CPU data address
//   WriteData  master->slave  32  CPU store data
//   ReadData   slave->master  32  register read data (combinational)
//   hit        slave->master  1   address falls inside the timer window
`timescale 1ns/1ps

interface mmio_timer_irq_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  modport master (
    output MemWrite, DataAdr, WriteData,
    input  ReadData, hit
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData,
    output ReadData, hit
  );
endinterface : mmio_timer_irq_if

// File: rtl/mmio_timer_irq.sv
// mmio_timer_irq
// --------------
// Memory-mapped countdown timer and level interrupt source. It responds on
// the core's data-memory bus inside a 32-byte window at BASE_ADDR.
//
// Register map (byte offsets; DataAdr[1:0] are ignored):
//   0x00 CTRL    R/W  bit0 EN, bit1 AUTO (reload on expiry), bit2 IE
//   0x04 LOAD    R/W  a write also loads COUNT on the same edge
//   0x08 COUNT   RO
//   0x0C STATUS  bit0 PEND, write 1 to clear
//   0x10 PRESC   R/W  only when TIMER_PRESCALE_EN is defined
//   All other offsets read 0 and ignore writes.
//
// Optional feature macro: TIMER_PRESCALE_EN. When it is defined, a prescale
// counter divides the tick rate by (PRESC+1). When it is undefined, the
// timer ticks every cycle and offset 0x10 reads 0.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   synchronous active-low reset
//   bus        slave modport of mmio_timer_irq_if
//   interrupt  out  level interrupt request, PEND & IE, driven from a flop
`timescale 1ns/1ps

module mmio_timer_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  mmio_timer_irq_if.slave bus,
  output logic            interrupt
);

  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_LOAD   = 3'd1,
    OFF_COUNT  = 3'd2,
    OFF_STATUS = 3'd3,
    OFF_PRESC  = 3'd4
  } reg_off_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Architectural state
  logic             r_en;
  logic             r_auto;
  logic             r_ie;
  logic [CNT_W-1:0] r_load;
  logic [CNT_W-1:0] r_count;
  logic             r_pend;
  logic             r_irq;

  // Decode and next-state values
  logic             w_hit;
  reg_off_e         w_off;
  logic             w_wr;
  logic             w_tick;
  logic             w_expire;
  logic             w_en_nxt;
  logic             w_auto_nxt;
  logic             w_ie_nxt;
  logic [CNT_W-1:0] w_load_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_pend_nxt;
  logic             w_unused;

  assign w_hit    = (bus.DataAdr[31:5] == BASE_ADDR[31:5]);
  assign w_off    = reg_off_e'(bus.DataAdr[4:2]);
  assign w_wr     = bus.MemWrite & w_hit;
  assign bus.hit  = w_hit;
  // Byte-lane bits are not part of the decode.
  assign w_unused = &{1'b0, bus.DataAdr[1:0]};

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_psc_cnt;
  logic               w_presc_wr;

  assign w_presc_wr = w_wr && (w_off == OFF_PRESC);
  // The tick fires on the edge where the counter has reached PRESC.
  assign w_tick     = (r_psc_cnt == r_presc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_presc   <= '0;
      r_psc_cnt <= '0;
    end else begin
      if (w_presc_wr) begin
        r_presc <= bus.WriteData[PRESC_W-1:0];
      end
      // A PRESC write restarts the division. A disabled timer parks the
      // counter at 0, so re-enabling always waits a full PRESC+1 cycles.
      if (w_presc_wr || !r_en || w_tick) begin
        r_psc_cnt <= '0;
      end else begin
        r_psc_cnt <= r_psc_cnt + 1'b1;
      end
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Next-state logic. Time effects (decrement or expiry) are applied first
  // and bus writes second, so a LOAD write overrides a decrement. The
  // expiry is applied last, so it overrides a same-edge W1C.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_expire    = 1'b0;
    w_en_nxt    = r_en;
    w_auto_nxt  = r_auto;
    w_ie_nxt    = r_ie;
    w_load_nxt  = r_load;
    w_count_nxt = r_count;
    w_pend_nxt  = r_pend;

    // EN is the pre-edge value here, so a CTRL write that clears EN still
    // lets an expiry on that same edge happen.
    if (r_en && w_tick && (r_count != '0)) begin
      if (r_count == CNT_ONE) begin
        w_expire    = 1'b1;
        w_count_nxt = r_auto ? r_load : '0;
      end else begin
        w_count_nxt = r_count - CNT_ONE;
      end
    end

    if (w_wr) begin
      case (w_off)
        OFF_CTRL: begin
          w_en_nxt   = bus.WriteData[0];
          w_auto_nxt = bus.WriteData[1];
          w_ie_nxt   = bus.WriteData[2];
        end
        OFF_LOAD: begin
          w_load_nxt  = bus.WriteData[CNT_W-1:0];
          w_count_nxt = bus.WriteData[CNT_W-1:0];
        end
        OFF_STATUS: begin
          if (bus.WriteData[0]) begin
            w_pend_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (w_expire) begin
      w_pend_nxt = 1'b1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments,
  // so every flop samples its next value from the same pre-edge state.
  always_ff @(posedge clk) begin
    // NOTE: the synchronous reset covers every state bit; nothing here is
    // a memory array, so there is no reset-less storage to leave alone.
    if (!reset) begin
      r_en    <= 1'b0;
      r_auto  <= 1'b0;
      r_ie    <= 1'b0;
      r_load  <= '0;
      r_count <= '0;
      r_pend  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_en    <= w_en_nxt;
      r_auto  <= w_auto_nxt;
      r_ie    <= w_ie_nxt;
      r_load  <= w_load_nxt;
      r_count <= w_count_nxt;
      r_pend  <= w_pend_nxt;
      // The request is registered from next-state values, so it changes on
      // the same edge as PEND/IE and cannot glitch between edges.
      r_irq   <= w_pend_nxt & w_ie_nxt;
    end
  end

  assign interrupt = r_irq;

  // Read mux: combinational from DataAdr, no side effects.
  always_comb begin
    bus.ReadData = '0;
    if (w_hit) begin
      case (w_off)
        OFF_CTRL:   bus.ReadData = {29'd0, r_ie, r_auto, r_en};
        OFF_LOAD:   bus.ReadData = 32'(r_load);
        OFF_COUNT:  bus.ReadData = 32'(r_count);
        OFF_STATUS: bus.ReadData = {31'd0, r_pend};
`ifdef TIMER_PRESCALE_EN
        OFF_PRESC:  bus.ReadData = 32'(r_presc);
`endif
        default:    bus.ReadData = '0;
      endcase
    end
  end

endmodule : mmio_timer_irq

// File: tb/tb_mmio_timer_irq.sv
// tb_mmio_timer_irq
// -----------------
// Self-checking bench for mmio_timer_irq. A behavioural timer model tracks
// the register file from bus traffic. Directed scenarios also carry literal
// expectations for the key sequences, and a randomized phase compares read
// data, hit and interrupt against the model on every cycle.
`timescale 1ns/1ps

module tb_mmio_timer_irq;

  localparam logic [31:0] BASE     = 32'h0000_0080;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_LOAD   = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;
  localparam logic [31:0] A_PRESC  = BASE + 32'h10;

  logic clk = 1'b0;
  logic reset;
  logic interrupt;

  mmio_timer_irq_if bus ();

  mmio_timer_irq #(
    .BASE_ADDR (BASE),
    .CNT_W     (32),
    .PRESC_W   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural model ----------------
  bit          m_en, m_auto, m_ie, m_pend;
  int unsigned m_load, m_count;
  int unsigned m_presc, m_pcnt;

  function automatic bit m_hit(logic [31:0] a);
    return (a & 32'hFFFF_FFE0) == BASE;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    logic [31:0] word;
    if (!m_hit(a)) return 32'd0;
    word = (a >> 2) & 32'd7;
    case (word)
      32'd0: return {29'd0, m_ie, m_auto, m_en};
      32'd1: return m_load;
      32'd2: return m_count;
      32'd3: return {31'd0, m_pend};
`ifdef TIMER_PRESCALE_EN
      32'd4: return m_presc;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_irq();
    return m_pend & m_ie;
  endfunction

  // One rising edge of the timer. The countdown advances first from the
  // old settings, then the bus store lands, and an expiry sets PEND last.
  task automatic model_step(bit we, logic [31:0] a, logic [31:0] d, bit rst_n);
    bit tick;
    bit fired;
    logic [31:0] word;
    if (!rst_n) begin
      {m_en, m_auto, m_ie, m_pend} = 4'b0;
      m_load = 0; m_count = 0; m_presc = 0; m_pcnt = 0;
      return;
    end
`ifdef TIMER_PRESCALE_EN
    tick   = (m_pcnt == m_presc);
    m_pcnt = (!m_en || tick) ? 0 : m_pcnt + 1;
`else
    tick = 1'b1;
`endif
    fired = 1'b0;
    if (m_en && tick && m_count != 0) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        fired = 1'b1;
        if (m_auto) m_count = m_load;
      end
    end
    if (we && m_hit(a)) begin
      word = (a >> 2) & 32'd7;
      case (word)
        32'd0: {m_ie, m_auto, m_en} = d[2:0];
        32'd1: begin m_load = d; m_count = d; end
        32'd3: if (d[0]) m_pend = 1'b0;
`ifdef TIMER_PRESCALE_EN
        32'd4: begin m_presc = {16'd0, d[15:0]}; m_pcnt = 0; end
`endif
        default: ;
      endcase
    end
    if (fired) m_pend = 1'b1;
  endtask

  // ---------------- bus driving ----------------
  // Inputs change 1 ns after a rising edge; outputs are sampled between edges.
  task automatic drive(bit we, logic [31:0] a, logic [31:0] d);
    bus.MemWrite  = we;
    bus.DataAdr   = a;
    bus.WriteData = d;
    @(posedge clk);
    model_step(we, a, d, reset);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    drive(1'b1, a, d);
  endtask

  task automatic idle();
    drive(1'b0, A_COUNT, 32'd0);
  endtask

  task automatic peek(logic [31:0] a);
    bus.MemWrite = 1'b0;
    bus.DataAdr  = a;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] addrs [4];
    addrs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS};
    reset = 1'b0;
    idle();
    idle();
    reset = 1'b1;
    n_checks++;
    if (interrupt !== 1'b0) begin
      n_errors++; $display("FAIL reset_irq: got %b want 0", interrupt);
    end
    foreach (addrs[i]) begin
      peek(addrs[i]);
      n_checks++;
      if (bus.ReadData !== 32'd0 || bus.hit !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_read %h: got data %h hit %b want 0 / 1", addrs[i], bus.ReadData, bus.hit);
      end
    end
    peek(32'h0000_0064);
    n_checks++;
    if (bus.hit !== 1'b0 || bus.ReadData !== 32'd0) begin
      n_errors++; $display("FAIL decode_miss: got hit %b data %h want 0 / 0", bus.hit, bus.ReadData);
    end
  endtask

  task automatic test_one_shot();
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 4; i++) begin
      peek(A_COUNT);
      n_checks++;
      if (bus.ReadData !== 32'(3 - i) || bus.ReadData !== m_read(A_COUNT)) begin
        n_errors++; $display("FAIL oneshot_count[%0d]: got %0d want %0d", i, bus.ReadData, 3 - i);
      end
      n_checks++;
      if (interrupt !== (i == 3) || interrupt !== m_irq()) begin
        n_errors++; $display("FAIL oneshot_irq[%0d]: got %b want %b", i, interrupt, i == 3);
      end
      if (i < 3) idle();
    end
    idle();
    idle();
    peek(A_COUNT);
    n_checks++;
    if (bus.ReadData !== 32'd0 || interrupt !== 1'b1) begin
      n_errors++; $display("FAIL oneshot_hold: got count %0d irq %b want 0 / 1", bus.ReadData, interrupt);
    end
  endtask

  task automatic test_w1c_race();
    wr(A_STATUS, 32'd1);
    peek(A_STATUS);
    n_checks++;
    if (bus.ReadData !== 32'd0 || interrupt !== 1'b0) begin
      n_errors++; $display("FAIL w1c_clear: got pend %0d irq %b want 0 / 0", bus.ReadData, interrupt);
    end
    wr(A_CTRL, 32'h0);
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h7);
    idle();
    wr(A_STATUS, 32'd1);   // lands on the expiry edge
    peek(A_STATUS);
    n_checks++;
    if (bus.ReadData !== 32'd1 || bus.ReadData !== m_read(A_STATUS) || interrupt !== 1'b1) begin
      n_errors++; $display("FAIL w1c_race: got pend %0d irq %b want 1 / 1", bus.ReadData, interrupt);
    end
    peek(A_COUNT);
    n_checks++;
    if (bus.ReadData !== 32'd2) begin
      n_errors++; $display("FAIL w1c_race_reload: got %0d want 2", bus.ReadData);
    end
  endtask

  task automatic test_auto_reload();
    bit want_pend;
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'd1);
    wr(A_LOAD, 32'd4);
    wr(A_CTRL, 32'h7);
    for (int j = 0; j < 12; j++) begin
      want_pend = (j % 4 == 0) && (j > 0);
      peek(A_COUNT);
      n_checks++;
      if (bus.ReadData !== 32'(4 - (j % 4)) || bus.ReadData !== m_read(A_COUNT)) begin
        n_errors++; $display("FAIL auto_count[%0d]: got %0d want %0d", j, bus.ReadData, 4 - (j % 4));
      end
      n_checks++;
      if (interrupt !== want_pend || interrupt !== m_irq()) begin
        n_errors++; $display("FAIL auto_irq[%0d]: got %b want %b", j, interrupt, want_pend);
      end
      if (want_pend) wr(A_STATUS, 32'd1);
      else idle();
    end
  endtask

  task automatic test_mask_freeze();
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'd1);
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h5);
    idle();
    n_checks++;
    if (interrupt !== 1'b1) begin
      n_errors++; $display("FAIL mask_pre: got irq %b want 1", interrupt);
    end
    wr(A_CTRL, 32'h1);
    peek(A_STATUS);
    n_checks++;
    if (interrupt !== 1'b0 || bus.ReadData !== 32'd1) begin
      n_errors++; $display("FAIL mask: got irq %b pend %0d want 0 / 1", interrupt, bus.ReadData);
    end
    wr(A_LOAD, 32'd8);
    idle();
    idle();
    wr(A_CTRL, 32'h0);     // EN still 1 before this edge: 6 -> 5
    for (int k = 0; k < 10; k++) begin
      peek(A_COUNT);
      n_checks++;
      if (bus.ReadData !== 32'd5 || bus.ReadData !== m_read(A_COUNT)) begin
        n_errors++; $display("FAIL freeze[%0d]: got %0d want 5", k, bus.ReadData);
      end
      idle();
    end
    wr(A_CTRL, 32'h1);
    idle();
    peek(A_COUNT);
    n_checks++;
    if (bus.ReadData !== 32'd4) begin
      n_errors++; $display("FAIL resume: got %0d want 4", bus.ReadData);
    end
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale();
    int unsigned want;
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'd1);
    wr(A_PRESC, 32'd2);
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h5);
    for (int k = 1; k <= 6; k++) begin
      idle();
      want = 2 - (k / 3);
      peek(A_COUNT);
      n_checks++;
      if (bus.ReadData !== want || bus.ReadData !== m_read(A_COUNT)) begin
        n_errors++; $display("FAIL presc_count[%0d]: got %0d want %0d", k, bus.ReadData, want);
      end
      n_checks++;
      if (interrupt !== (k == 6)) begin
        n_errors++; $display("FAIL presc_irq[%0d]: got %b want %b", k, interrupt, k == 6);
      end
    end
  endtask
`endif

  task automatic test_reset_midcount();
    logic [31:0] addrs [5];
    addrs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS, A_PRESC};
    wr(A_STATUS, 32'd1);
    wr(A_LOAD, 32'd10);
    wr(A_CTRL, 32'h7);
    idle();
    idle();
    idle();
    reset = 1'b0;
    idle();
    reset = 1'b1;
    foreach (addrs[i]) begin
      peek(addrs[i]);
      n_checks++;
      if (bus.ReadData !== 32'd0) begin
        n_errors++; $display("FAIL midreset_read %h: got %h want 0", addrs[i], bus.ReadData);
      end
    end
    for (int k = 0; k < 12; k++) idle();
    peek(A_COUNT);
    n_checks++;
    if (interrupt !== 1'b0 || bus.ReadData !== 32'd0) begin
      n_errors++; $display("FAIL midreset_hold: got irq %b count %0d want 0 / 0", interrupt, bus.ReadData);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, wa, wd;
    int unsigned off, r;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0:       ra = 32'h0000_0064;
        1:       ra = 32'h0000_00A0;
        2:       ra = 32'h0000_007C;
        default: ra = BASE + 32'($urandom_range(0, 31));
      endcase
      peek(ra);
      n_checks++;
      if (bus.ReadData !== m_read(ra) || bus.hit !== m_hit(ra) || interrupt !== m_irq()) begin
        n_errors++;
        $display("FAIL random[%0d] @%h: got data %h hit %b irq %b want %h / %b / %b",
                 it, ra, bus.ReadData, bus.hit, interrupt, m_read(ra), m_hit(ra), m_irq());
      end
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b0;
        idle();
        reset = 1'b1;
      end else if (r < 35) begin
        off = $urandom_range(0, 7);
        case (off)
          0:       wd = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
          1:       wd = 32'($urandom_range(0, 7));
          4:       wd = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
          default: wd = $urandom;
        endcase
        wa = (r < 5) ? 32'h0000_0060 : BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
        wr(wa, wd);
      end else begin
        idle();
      end
    end
  endtask

  initial begin
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = 32'd0;
    bus.WriteData = 32'd0;
    reset         = 1'b0;
    test_reset();
    test_one_shot();
    test_w1c_race();
    test_auto_reload();
    test_mask_freeze();
`ifdef TIMER_PRESCALE_EN
    test_prescale();
`endif
    test_reset_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mmio_timer_irq
